bus_controller: RTL and testbench

- Parametrised successor to the hand-wired SAP bus select logic: a common control plane for N_MOD bus modules (PC, Acc, B, ALU, MAR, RAM, IR, OR, ...).
- Debounces the breadboard go button and applies sel/oe_req/we_req/en_req to the selected module's control bits. The controls latch per module, so several modules can hold settings at once.
- Drives a registered shared bus from exactly one output-enabled module and flags bus conflicts.
- Sits in main between the switches and every datapath module.

---
 rtl/bus_controller.sv | 242 ++++++++++++++++++++++++
 tb/tb_bus_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_controller.sv
// -----------------------------------------------------------------------------
// bus_controller
//
// Common control plane for N_MOD bus modules (PC, Acc, B, ALU, MAR, RAM, IR,
// OR, ...). A debounced "go" press applies the requested output/write/count
// enables to the selected module. Each module's control bits are latched
// independently, so several modules can hold settings at the same time. The
// shared bus is a register loaded from the single output-enabled module. When
// more than one module drives, the bus flags a conflict and holds its value.
//
// Ports:
//   CLK        system clock, all state updates on posedge
//   RESET      asynchronous, active-low reset
//   go         raw breadboard button (asynchronous)
//   sel        target module index; values >= N_MOD are invalid
//   oe_req     requested output enable for the target
//   we_req     requested write enable (load) for the target
//   en_req     requested count/run enable for the target
//   HLT        level-sensitive halt
//   mod_data   module outputs, module k at [k*DATA_W +: DATA_W]
//   oe_vec     per-module output enables
//   we_vec     per-module write enables
//   en_vec     per-module count/run enables
//   bus        registered shared bus
//   bus_valid  exactly one oe_vec bit was set when bus was last evaluated
//   conflict   more than one oe_vec bit is set (registered)
//   go_db      debounced go level
//   sel_err    one-cycle pulse when a press targets an invalid module
//   xfer_done  one-cycle pulse when the bus first reflects an applied command
//   halted     controller is in the HALTED state
// -----------------------------------------------------------------------------
module bus_controller #(
  parameter int DATA_W = 8,
  parameter int N_MOD  = 9,
  parameter int SEL_W  = 4,
  parameter int DB_W   = 16
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    go,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    oe_req,
  input  logic                    we_req,
  input  logic                    en_req,
  input  logic                    HLT,
  input  logic [N_MOD*DATA_W-1:0] mod_data,
  output logic [N_MOD-1:0]        oe_vec,
  output logic [N_MOD-1:0]        we_vec,
  output logic [N_MOD-1:0]        en_vec,
  output logic [DATA_W-1:0]       bus,
  output logic                    bus_valid,
  output logic                    conflict,
  output logic                    go_db,
  output logic                    sel_err,
  output logic                    xfer_done,
  output logic                    halted
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LATCH  = 2'd1;
  localparam logic [1:0] ST_DRIVE  = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  logic [1:0]        sync_q, sync_d;
  logic [DB_W-1:0]   cnt_q, cnt_d;
  logic              go_db_q, go_db_d;
  logic              go_db_prev_q, go_db_prev_d;
  logic [1:0]        state_q, state_d;
  logic [SEL_W-1:0]  cmd_sel_q, cmd_sel_d;
  logic              cmd_oe_q, cmd_oe_d;
  logic              cmd_we_q, cmd_we_d;
  logic              cmd_en_q, cmd_en_d;
  logic [N_MOD-1:0]  oe_q, oe_d;
  logic [N_MOD-1:0]  we_q, we_d;
  logic [N_MOD-1:0]  en_q, en_d;
  logic [DATA_W-1:0] bus_q, bus_d;
  logic              bus_valid_q, bus_valid_d;
  logic              conflict_q, conflict_d;
  logic              sel_err_q, sel_err_d;
  logic              xfer_done_q, xfer_done_d;

  logic go_s;
  logic go_rise;
  logic sel_ok;
  logic oe_none;
  logic oe_multi;

  // Two-flop synchronizer for the asynchronous button; go_s is the settled copy.
  assign sync_d  = {sync_q[0], go};
  assign go_s    = sync_q[1];

  // Only the press (rising debounced level) starts a command; release is ignored.
  assign go_rise      = go_db_q & ~go_db_prev_q;
  assign go_db_prev_d = go_db_q;

  assign sel_ok = (int'(cmd_sel_q) < N_MOD);

  // A new level must survive a full counter wrap before go_db follows it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    cnt_d   = cnt_q;
    go_db_d = go_db_q;
    if (go_s == go_db_q) begin
      cnt_d = '0;
    end else if (cnt_q == '1) begin
      go_db_d = go_s;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Command FSM: IDLE captures on a press, LATCH applies it, DRIVE lets the
  // bus register pick up the new enables and reports completion.
  always_comb begin
    state_d     = state_q;
    cmd_sel_d   = cmd_sel_q;
    cmd_oe_d    = cmd_oe_q;
    cmd_we_d    = cmd_we_q;
    cmd_en_d    = cmd_en_q;
    oe_d        = oe_q;
    we_d        = we_q;
    en_d        = en_q;
    sel_err_d   = 1'b0;
    xfer_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (go_rise) begin
          state_d   = ST_LATCH;
          cmd_sel_d = sel;
          cmd_oe_d  = oe_req;
          cmd_we_d  = we_req;
          cmd_en_d  = en_req;
        end
      end
      ST_LATCH: begin
        state_d = ST_DRIVE;
        if (sel_ok) begin
          // Write has priority: a module cannot load and drive in one command.
          we_d[cmd_sel_q] = cmd_we_q;
          oe_d[cmd_sel_q] = cmd_oe_q & ~cmd_we_q;
          en_d[cmd_sel_q] = cmd_en_q;
        end else begin
          sel_err_d = 1'b1;
        end
      end
      ST_DRIVE: begin
        state_d     = ST_IDLE;
        xfer_done_d = 1'b1;
      end
      ST_HALTED: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Halt overrides everything, including a command in flight.
    if (HLT) begin
      state_d     = ST_HALTED;
      sel_err_d   = 1'b0;
      xfer_done_d = 1'b0;
    end
    if (HLT || (state_q == ST_HALTED)) begin
      oe_d = '0;
      we_d = '0;
      en_d = '0;
    end
  end

  // Bus register: load only from a single driver; otherwise hold the last value.
  assign oe_none  = (oe_q == '0);
  assign oe_multi = |(oe_q & (oe_q - N_MOD'(1)));

  always_comb begin
    bus_d       = bus_q;
    bus_valid_d = !oe_none && !oe_multi;
    conflict_d  = oe_multi;
    if (!oe_none && !oe_multi) begin
      for (int k = 0; k < N_MOD; k++) begin
        if (oe_q[k]) bus_d = mod_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync_q       <= '0;
      cnt_q        <= '0;
      go_db_q      <= 1'b0;
      go_db_prev_q <= 1'b0;
      state_q      <= ST_IDLE;
      cmd_sel_q    <= '0;
      cmd_oe_q     <= 1'b0;
      cmd_we_q     <= 1'b0;
      cmd_en_q     <= 1'b0;
      oe_q         <= '0;
      we_q         <= '0;
      en_q         <= '0;
      bus_q        <= '0;
      bus_valid_q  <= 1'b0;
      conflict_q   <= 1'b0;
      sel_err_q    <= 1'b0;
      xfer_done_q  <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      go_db_q      <= go_db_d;
      go_db_prev_q <= go_db_prev_d;
      state_q      <= state_d;
      cmd_sel_q    <= cmd_sel_d;
      cmd_oe_q     <= cmd_oe_d;
      cmd_we_q     <= cmd_we_d;
      cmd_en_q     <= cmd_en_d;
      oe_q         <= oe_d;
      we_q         <= we_d;
      en_q         <= en_d;
      bus_q        <= bus_d;
      bus_valid_q  <= bus_valid_d;
      conflict_q   <= conflict_d;
      sel_err_q    <= sel_err_d;
      xfer_done_q  <= xfer_done_d;
    end
  end

  assign oe_vec    = oe_q;
  assign we_vec    = we_q;
  assign en_vec    = en_q;
  assign bus       = bus_q;
  assign bus_valid = bus_valid_q;
  assign conflict  = conflict_q;
  assign go_db     = go_db_q;
  assign sel_err   = sel_err_q;
  assign xfer_done = xfer_done_q;
  assign halted    = (state_q == ST_HALTED);

endmodule

// File: tb/tb_bus_controller.sv
// -----------------------------------------------------------------------------
// tb_bus_controller
//
// Self-checking bench for bus_controller with DB_W=3, N_MOD=9. A reference
// model holds the per-module enables as plain bit arrays and derives the bus
// from the population count of the output enables; commands are applied by
// the model's own rules and compared against the DUT at fixed latencies after
// the debounced press.
// -----------------------------------------------------------------------------
module tb_bus_controller;

  localparam int DATA_W = 8;
  localparam int N_MOD  = 9;
  localparam int SEL_W  = 4;
  localparam int DB_W   = 3;

  logic                    CLK = 1'b0;
  logic                    RESET = 1'b0;
  logic                    go = 1'b0;
  logic [SEL_W-1:0]        sel = '0;
  logic                    oe_req = 1'b0;
  logic                    we_req = 1'b0;
  logic                    en_req = 1'b0;
  logic                    HLT = 1'b0;
  logic [N_MOD*DATA_W-1:0] mod_data = '0;
  logic [N_MOD-1:0]        oe_vec, we_vec, en_vec;
  logic [DATA_W-1:0]       bus;
  logic                    bus_valid, conflict, go_db, sel_err, xfer_done, halted;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [DATA_W-1:0] md [N_MOD];
  logic [N_MOD-1:0]  m_oe = '0;
  logic [N_MOD-1:0]  m_we = '0;
  logic [N_MOD-1:0]  m_en = '0;
  logic [DATA_W-1:0] m_bus = '0;

  bus_controller #(
    .DATA_W(DATA_W), .N_MOD(N_MOD), .SEL_W(SEL_W), .DB_W(DB_W)
  ) dut (
    .CLK(CLK), .RESET(RESET), .go(go), .sel(sel), .oe_req(oe_req),
    .we_req(we_req), .en_req(en_req), .HLT(HLT), .mod_data(mod_data),
    .oe_vec(oe_vec), .we_vec(we_vec), .en_vec(en_vec), .bus(bus),
    .bus_valid(bus_valid), .conflict(conflict), .go_db(go_db),
    .sel_err(sel_err), .xfer_done(xfer_done), .halted(halted)
  );

  always #5 CLK = ~CLK;

  // Model: the bus follows the sole output-enabled module, else holds.
  task automatic model_bus();
    if ($countones(m_oe) == 1) begin
      for (int k = 0; k < N_MOD; k++) if (m_oe[k]) m_bus = md[k];
    end
  endtask

  task automatic drive_data();
    for (int k = 0; k < N_MOD; k++) mod_data[k*DATA_W +: DATA_W] = md[k];
    model_bus();
  endtask

  // Wait (bounded) for go_db to reach lvl; returns cycles waited.
  task automatic wait_go_db(input logic lvl, output int cyc);
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (go_db !== lvl && cyc < 40);
  endtask

  // Press go with a command, then compare enables, pulses and bus at their
  // fixed offsets from the debounced press.
  task automatic run_cmd(input int id, input int s, input bit o, input bit w,
                         input bit e, input int exp_lat);
    int  cyc;
    bit  bad_sel;
    @(negedge CLK);
    sel = SEL_W'(s); oe_req = o; we_req = w; en_req = e; go = 1'b1;
    wait_go_db(1'b1, cyc);
    n_cmp++;
    if (go_db !== 1'b1) begin
      n_bad++; $display("FAIL cmd%0d go_db_timeout got %b exp 1", id, go_db);
    end
    if (exp_lat >= 0) begin
      n_cmp++;
      if (cyc != exp_lat) begin
        n_bad++; $display("FAIL cmd%0d debounce_latency got %0d exp %0d", id, cyc, exp_lat);
      end
    end
    bad_sel = (s >= N_MOD);
    if (!bad_sel) begin
      m_we[s] = w;
      m_oe[s] = o && !w;
      m_en[s] = e;
    end
    model_bus();
    @(negedge CLK);  // LATCH
    @(negedge CLK);  // DRIVE: enables now visible
    n_cmp++;
    if (oe_vec !== m_oe) begin n_bad++; $display("FAIL cmd%0d oe_vec got %b exp %b", id, oe_vec, m_oe); end
    n_cmp++;
    if (we_vec !== m_we) begin n_bad++; $display("FAIL cmd%0d we_vec got %b exp %b", id, we_vec, m_we); end
    n_cmp++;
    if (en_vec !== m_en) begin n_bad++; $display("FAIL cmd%0d en_vec got %b exp %b", id, en_vec, m_en); end
    n_cmp++;
    if (sel_err !== bad_sel) begin n_bad++; $display("FAIL cmd%0d sel_err got %b exp %b", id, sel_err, bad_sel); end
    n_cmp++;
    if (xfer_done !== 1'b0) begin n_bad++; $display("FAIL cmd%0d xfer_done_early got %b exp 0", id, xfer_done); end
    @(negedge CLK);  // bus reflects the command
    n_cmp++;
    if (xfer_done !== 1'b1) begin n_bad++; $display("FAIL cmd%0d xfer_done got %b exp 1", id, xfer_done); end
    n_cmp++;
    if (sel_err !== 1'b0) begin n_bad++; $display("FAIL cmd%0d sel_err_len got %b exp 0", id, sel_err); end
    n_cmp++;
    if (bus !== m_bus) begin n_bad++; $display("FAIL cmd%0d bus got %h exp %h", id, bus, m_bus); end
    n_cmp++;
    if (bus_valid !== ($countones(m_oe) == 1)) begin
      n_bad++; $display("FAIL cmd%0d bus_valid got %b exp %b", id, bus_valid, $countones(m_oe) == 1);
    end
    n_cmp++;
    if (conflict !== ($countones(m_oe) > 1)) begin
      n_bad++; $display("FAIL cmd%0d conflict got %b exp %b", id, conflict, $countones(m_oe) > 1);
    end
    go = 1'b0;
    repeat (14) @(negedge CLK);
    n_cmp++;
    if (xfer_done !== 1'b0 || go_db !== 1'b0) begin
      n_bad++; $display("FAIL cmd%0d release got xfer=%b go_db=%b exp 0 0", id, xfer_done, go_db);
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({oe_vec, we_vec, en_vec, bus, bus_valid, conflict, go_db, sel_err, xfer_done, halted} !== '0) begin
      n_bad++; $display("FAIL reset_async got %b exp 0",
        {oe_vec, we_vec, en_vec, bus, bus_valid, conflict, go_db, sel_err, xfer_done, halted});
    end
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if ({oe_vec, we_vec, en_vec, bus, bus_valid, conflict, go_db, sel_err, xfer_done, halted} !== '0) begin
      n_bad++; $display("FAIL reset_release got %b exp 0",
        {oe_vec, we_vec, en_vec, bus, bus_valid, conflict, go_db, sel_err, xfer_done, halted});
    end
  endtask

  task automatic test_glitch();
    bit seen = 0;
    @(negedge CLK);
    go = 1'b1;
    repeat (5) @(negedge CLK);
    go = 1'b0;
    repeat (15) begin
      @(negedge CLK);
      if (go_db !== 1'b0 || xfer_done !== 1'b0) seen = 1;
    end
    n_cmp++;
    if (seen) begin n_bad++; $display("FAIL glitch go_db got 1 exp 0"); end
  endtask

  task automatic test_halt();
    int  cyc;
    bit  bad = 0;
    run_cmd(10, 0, 1'b0, 1'b0, 1'b1, -1);  // en_vec[0] = 1
    @(negedge CLK);
    HLT = 1'b1;
    m_oe = '0; m_we = '0; m_en = '0;
    @(negedge CLK);
    n_cmp++;
    if ({oe_vec, we_vec, en_vec} !== '0) begin
      n_bad++; $display("FAIL halt_vectors got %b exp 0", {oe_vec, we_vec, en_vec});
    end
    n_cmp++;
    if (halted !== 1'b1) begin n_bad++; $display("FAIL halt_flag got %b exp 1", halted); end
    sel = 4'd3; oe_req = 1'b1; we_req = 1'b1; en_req = 1'b1; go = 1'b1;
    wait_go_db(1'b1, cyc);
    repeat (6) begin
      @(negedge CLK);
      if ({oe_vec, we_vec, en_vec} !== '0 || xfer_done !== 1'b0 || halted !== 1'b1) bad = 1;
    end
    n_cmp++;
    if (bad) begin n_bad++; $display("FAIL halt_press_ignored got activity exp none"); end
    go = 1'b0;
    repeat (14) @(negedge CLK);
    HLT = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (halted !== 1'b0) begin n_bad++; $display("FAIL halt_exit got %b exp 0", halted); end
    n_cmp++;
    if ({oe_vec, we_vec, en_vec} !== '0) begin
      n_bad++; $display("FAIL halt_exit_vectors got %b exp 0", {oe_vec, we_vec, en_vec});
    end
    run_cmd(11, 3, 1'b1, 1'b0, 1'b0, -1);  // IDLE accepts commands again
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      for (int k = 0; k < N_MOD; k++) md[k] = DATA_W'($urandom);
      drive_data();
      run_cmd(20 + i, int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
              1'($urandom), -1);
    end
  endtask

  task automatic test_reset_mid();
    int  cyc;
    bit  bad = 0;
    @(negedge CLK);
    sel = 4'd5; oe_req = 1'b1; we_req = 1'b0; en_req = 1'b1; go = 1'b1;
    wait_go_db(1'b1, cyc);
    @(negedge CLK);  // command is in flight
    RESET = 1'b0;
    go = 1'b0;
    m_oe = '0; m_we = '0; m_en = '0; m_bus = '0;
    #1;
    n_cmp++;
    if ({oe_vec, we_vec, en_vec, bus, go_db, halted} !== '0) begin
      n_bad++; $display("FAIL reset_mid got %b exp 0", {oe_vec, we_vec, en_vec, bus, go_db, halted});
    end
    @(negedge CLK);
    RESET = 1'b1;
    repeat (20) begin
      @(negedge CLK);
      if (xfer_done !== 1'b0 || {oe_vec, we_vec, en_vec} !== '0) bad = 1;
    end
    n_cmp++;
    if (bad) begin n_bad++; $display("FAIL reset_mid_abort got activity exp none"); end
  endtask

  initial begin
    for (int k = 0; k < N_MOD; k++) md[k] = DATA_W'($urandom);
    md[1] = 8'hA5;
    drive_data();
    test_reset();
    test_glitch();
    run_cmd(1, 1, 1'b1, 1'b0, 1'b0, 10);  // single driver: bus = A5
    run_cmd(2, 2, 1'b1, 1'b0, 1'b0, -1);  // conflict: bus holds A5
    run_cmd(3, 2, 1'b1, 1'b1, 1'b0, -1);  // write wins, conflict clears
    run_cmd(4, 12, 1'b1, 1'b1, 1'b1, -1); // invalid select
    test_halt();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
